// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte/halfword/word accesses with load extension and
// optional splitting of misaligned accesses into several RAM beats.

package lsu_pkg;
  typedef enum logic [1:0] {
    WRITE_BYTE     = 2'd0,
    WRITE_HALFWORD = 2'd1,
    WRITE_WORD     = 2'd2
  } write_width_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [XLEN-1:0] ram_addr,
  output logic [XLEN-1:0] ram_w_data,
  output write_width_t    ram_w_width,
  output logic            ram_w_enable,
  input  logic [XLEN-1:0] ram_r_data
);

  typedef enum logic [1:0] {IDLE, LD1, LD2, ST} state_t;

  state_t state, state_next;

  logic [2:0]      op_funct3;
  logic [XLEN-1:0] op_addr;
  logic [XLEN-1:0] op_wdata;
  logic            op_misaligned;
  logic [XLEN-1:0] partial;
  logic [1:0]      beat;
  logic [1:0]      beat_last;

  logic            accept;
  logic            req_legal;
  logic            req_misaligned;
  logic            req_fault;
  logic            resp_set;
  logic            resp_fault_next;
  logic [XLEN-1:0] resp_rdata_next;
  logic [XLEN-1:0] next_word_addr;
  logic [5:0]      merge_shift;
  logic [XLEN-1:0] merged;

  function automatic write_width_t width_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return WRITE_BYTE;
      2'b01:   return WRITE_HALFWORD;
      default: return WRITE_WORD;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] v);
    case (f3)
      3'b000:  return {{(XLEN-8){v[7]}}, v[7:0]};
      3'b001:  return {{(XLEN-16){v[15]}}, v[15:0]};
      3'b100:  return {{(XLEN-8){1'b0}}, v[7:0]};
      3'b101:  return {{(XLEN-16){1'b0}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign req_ready = reset_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    if (req_is_store) begin
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    req_fault = !req_legal || (req_misaligned && !ALLOW_MISALIGNED);
  end

  // Second half of a split load comes from the next word; the RAM has already
  // shifted the first word down, so the second one is shifted up to meet it.
  assign next_word_addr = {op_addr[XLEN-1:2], 2'b00} + {{(XLEN-3){1'b0}}, 3'd4};
  assign merge_shift    = {3'd4 - {1'b0, op_addr[1:0]}, 3'b000};
  assign merged         = partial | (ram_r_data << merge_shift);
  assign beat_last      = (op_funct3[1:0] == 2'b01) ? 2'd1 : 2'd3;

  always_comb begin
    state_next      = state;
    ram_addr        = req_addr;
    ram_w_data      = req_wdata;
    ram_w_width     = width_of(req_funct3);
    ram_w_enable    = 1'b0;
    resp_set        = 1'b0;
    resp_rdata_next = '0;
    resp_fault_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            resp_set        = 1'b1;
            resp_fault_next = 1'b1;
          end else if (req_is_store) begin
            ram_w_enable = 1'b1;
            if (req_misaligned) begin
              ram_w_width = WRITE_BYTE;
              state_next  = ST;
            end else begin
              resp_set = 1'b1;
            end
          end else begin
            state_next = LD1;
          end
        end
      end
      LD1: begin
        if (op_misaligned) begin
          ram_addr   = next_word_addr;
          state_next = LD2;
        end else begin
          ram_addr        = op_addr;
          resp_set        = 1'b1;
          resp_rdata_next = extend(op_funct3, ram_r_data);
          state_next      = IDLE;
        end
      end
      LD2: begin
        ram_addr        = next_word_addr;
        resp_set        = 1'b1;
        resp_rdata_next = extend(op_funct3, merged);
        state_next      = IDLE;
      end
      ST: begin
        ram_addr     = op_addr + {{(XLEN-2){1'b0}}, beat};
        ram_w_data   = {{(XLEN-8){1'b0}}, op_wdata[{beat, 3'b000} +: 8]};
        ram_w_width  = WRITE_BYTE;
        ram_w_enable = 1'b1;
        if (beat == beat_last) begin
          resp_set   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_fault    <= 1'b0;
      op_funct3     <= 3'b000;
      op_addr       <= '0;
      op_wdata      <= '0;
      op_misaligned <= 1'b0;
      partial       <= '0;
      beat          <= 2'd0;
    end else begin
      state      <= state_next;
      resp_valid <= resp_set;
      resp_rdata <= resp_rdata_next;
      resp_fault <= resp_fault_next;
      if (accept) begin
        op_funct3     <= req_funct3;
        op_addr       <= req_addr;
        op_wdata      <= req_wdata;
        op_misaligned <= req_misaligned;
        beat          <= 2'd1;
      end else if (state == ST) begin
        beat <= beat + 2'd1;
      end
      if (state == LD1) begin
        partial <= ram_r_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (misaligned split / misaligned fault),
// each with a byte-array RAM, checked against a byte-level reference memory.

module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        req_valid_m, req_valid_a;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic         m_req_ready, a_req_ready;
  logic         m_resp_valid, a_resp_valid;
  logic [31:0]  m_resp_rdata, a_resp_rdata;
  logic         m_resp_fault, a_resp_fault;
  logic [31:0]  m_ram_addr, a_ram_addr;
  logic [31:0]  m_ram_w_data, a_ram_w_data;
  write_width_t m_ram_w_width, a_ram_w_width;
  logic         m_ram_w_enable, a_ram_w_enable;
  logic [31:0]  m_ram_r_data, a_ram_r_data;

  logic [7:0] ram   [2][64];
  logic [7:0] model [2][64];

  int assert_count = 0;
  int fail_count   = 0;

  load_store_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_m (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid_m), .req_ready(m_req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(m_resp_valid), .resp_rdata(m_resp_rdata), .resp_fault(m_resp_fault),
    .ram_addr(m_ram_addr), .ram_w_data(m_ram_w_data), .ram_w_width(m_ram_w_width),
    .ram_w_enable(m_ram_w_enable), .ram_r_data(m_ram_r_data)
  );

  load_store_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid_a), .req_ready(a_req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault),
    .ram_addr(a_ram_addr), .ram_w_data(a_ram_w_data), .ram_w_width(a_ram_w_width),
    .ram_w_enable(a_ram_w_enable), .ram_r_data(a_ram_r_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM read: word containing the address, shifted down, zeroes past the word end
  function automatic logic [31:0] ram_read(input int s, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      if (int'(a[1:0]) + k < 4) v[8*k +: 8] = ram[s][int'(a[5:0]) + k];
    end
    return v;
  endfunction

  task automatic ram_write(input int s, input logic [31:0] a, input logic [31:0] d,
                           input write_width_t w);
    int n;
    n = (w == WRITE_BYTE) ? 1 : (w == WRITE_HALFWORD) ? 2 : 4;
    for (int k = 0; k < n; k++) ram[s][(int'(a[5:0]) + k) % 64] = d[8*k +: 8];
  endtask

  always @(posedge clock) begin
    m_ram_r_data <= ram_read(0, m_ram_addr);
    if (m_ram_w_enable) ram_write(0, m_ram_addr, m_ram_w_data, m_ram_w_width);
  end

  always @(posedge clock) begin
    a_ram_r_data <= ram_read(1, a_ram_addr);
    if (a_ram_w_enable) ram_write(1, a_ram_addr, a_ram_w_data, a_ram_w_width);
  end

  function automatic logic [31:0] ram_word(input int s, input int idx);
    return {ram[s][4*idx+3], ram[s][4*idx+2], ram[s][4*idx+1], ram[s][4*idx]};
  endfunction

  task automatic clear_mem(input int s);
    for (int i = 0; i < 64; i++) begin
      ram[s][i]   = 8'h00;
      model[s][i] = 8'h00;
    end
  endtask

  task automatic set_word(input int s, input int idx, input logic [31:0] v);
    for (int k = 0; k < 4; k++) begin
      ram[s][4*idx+k]   = v[8*k +: 8];
      model[s][4*idx+k] = v[8*k +: 8];
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Load value assembled byte by byte from the reference memory, then extended
  function automatic logic [31:0] model_load(input int s, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < size_of(f3); k++) v[8*k +: 8] = model[s][(int'(a[5:0]) + k) % 64];
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic predict(input int s, input bit is_store, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rd, output logic flt,
                         output int wr);
    int  n;
    bit  legal;
    bit  mis;
    n     = size_of(f3);
    legal = is_store ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (int'(addr[1:0]) % n) != 0;
    rd    = '0;
    flt   = 1'b0;
    wr    = 0;
    if (!legal || (mis && s == 1)) begin
      flt = 1'b1;
      lat = 1;
    end else if (is_store) begin
      for (int k = 0; k < n; k++) model[s][(int'(addr[5:0]) + k) % 64] = wdata[8*k +: 8];
      lat = mis ? n : 1;
      wr  = mis ? n : 1;
    end else begin
      rd  = model_load(s, f3, addr);
      lat = mis ? 3 : 2;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic sel_wen(input int s);
    return (s == 0) ? m_ram_w_enable : a_ram_w_enable;
  endfunction

  // Drives one request, then scrambles the request inputs and waits for the response
  task automatic apply_stimulus(input int s, input bit is_store, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit chained, output int lat, output logic [31:0] rdata,
                                output logic fault, output int writes, output bit ready);
    lat    = -1;
    rdata  = 'x;
    fault  = 1'bx;
    writes = 0;
    if (!chained) @(negedge clock);
    req_is_store = is_store;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    if (s == 0) req_valid_m = 1'b1;
    else        req_valid_a = 1'b1;
    #1;
    ready = (s == 0) ? m_req_ready : a_req_ready;
    if (sel_wen(s)) writes++;
    @(posedge clock);
    @(negedge clock);
    req_valid_m  = 1'b0;
    req_valid_a  = 1'b0;
    req_is_store = 1'($urandom);
    req_funct3   = 3'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      if (c > 1) @(negedge clock);
      #1;
      if (sel_wen(s)) writes++;
      if ((s == 0) ? m_resp_valid : a_resp_valid) begin
        lat   = c;
        rdata = (s == 0) ? m_resp_rdata : a_resp_rdata;
        fault = (s == 0) ? m_resp_fault : a_resp_fault;
      end
    end
  endtask

  task automatic run_op(input int s, input bit is_store, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit chained,
                        input string tag, output logic [31:0] obs_rdata);
    int          e_lat, e_wr, o_lat, o_wr;
    logic [31:0] e_rd;
    logic        e_flt, o_flt;
    bit          o_rdy;
    predict(s, is_store, f3, addr, wdata, e_lat, e_rd, e_flt, e_wr);
    apply_stimulus(s, is_store, f3, addr, wdata, chained, o_lat, obs_rdata, o_flt, o_wr, o_rdy);
    check_output({tag, " ready"}, 32'(o_rdy), 32'd1);
    check_output({tag, " latency"}, 32'(o_lat), 32'(e_lat));
    check_output({tag, " rdata"}, obs_rdata, e_rd);
    check_output({tag, " fault"}, 32'(o_flt), 32'(e_flt));
    check_output({tag, " writes"}, 32'(o_wr), 32'(e_wr));
  endtask

  task automatic compare_mem(input int s, input string tag);
    for (int w = 0; w < 16; w++) begin
      check_output($sformatf("%s word%0d", tag, w), ram_word(s, w),
                   {model[s][4*w+3], model[s][4*w+2], model[s][4*w+1], model[s][4*w]});
    end
  endtask

  initial begin
    logic [31:0] obs;
    int          resp_seen;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;

    reset_n      = 1'b0;
    req_valid_m  = 1'b0;
    req_valid_a  = 1'b0;
    req_is_store = 1'b0;
    req_funct3   = 3'b000;
    req_addr     = '0;
    req_wdata    = '0;
    clear_mem(0);
    clear_mem(1);

    #1;
    check_output("reset ready", 32'(m_req_ready), 32'd0);
    check_output("reset resp_valid", 32'(m_resp_valid), 32'd0);
    check_output("reset resp_rdata", m_resp_rdata, 32'd0);
    check_output("reset resp_fault", 32'(m_resp_fault), 32'd0);
    check_output("reset w_enable", 32'(m_ram_w_enable), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] sign/zero extended byte loads");
    set_word(0, 0, 32'h8899_AABB);
    run_op(0, 1'b0, 3'b000, 32'd1, 32'd0, 1'b0, "lb1", obs);
    check_output("lb1 const", obs, 32'hFFFF_FFAA);
    run_op(0, 1'b0, 3'b100, 32'd1, 32'd0, 1'b0, "lbu1", obs);
    check_output("lbu1 const", obs, 32'h0000_00AA);

    $display("[TB] misaligned loads across a word boundary");
    set_word(0, 0, 32'h4433_2211);
    set_word(0, 1, 32'h8877_6655);
    run_op(0, 1'b0, 3'b010, 32'd3, 32'd0, 1'b0, "lw3", obs);
    check_output("lw3 const", obs, 32'h7766_5544);
    run_op(0, 1'b0, 3'b001, 32'd3, 32'd0, 1'b0, "lh3", obs);
    check_output("lh3 const", obs, 32'h0000_5544);

    $display("[TB] misaligned word store");
    clear_mem(0);
    run_op(0, 1'b1, 3'b010, 32'd2, 32'hDEAD_BEEF, 1'b0, "sw2", obs);
    check_output("sw2 word0", ram_word(0, 0), 32'hBEEF_0000);
    check_output("sw2 word1", ram_word(0, 1), 32'h0000_DEAD);

    $display("[TB] faults with splitting disabled");
    run_op(1, 1'b0, 3'b001, 32'd1, 32'd0, 1'b0, "strict lh1", obs);
    run_op(1, 1'b0, 3'b011, 32'd0, 32'd0, 1'b0, "strict ld011", obs);
    run_op(1, 1'b1, 3'b010, 32'd4, 32'hCAFE_F00D, 1'b0, "strict sw4", obs);
    run_op(1, 1'b0, 3'b010, 32'd4, 32'd0, 1'b0, "strict lw4", obs);

    $display("[TB] back-to-back requests");
    clear_mem(0);
    run_op(0, 1'b1, 3'b010, 32'd0, 32'h1234_5678, 1'b0, "b2b sw", obs);
    run_op(0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, "b2b lw", obs);
    check_output("b2b lw const", obs, 32'h1234_5678);
    run_op(0, 1'b1, 3'b000, 32'd0, 32'h0000_00FF, 1'b1, "b2b sb", obs);
    check_output("b2b word0", ram_word(0, 0), 32'h1234_56FF);

    $display("[TB] address wrap");
    run_op(0, 1'b1, 3'b010, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 1'b0, "wrap sw", obs);
    run_op(0, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0, 1'b0, "wrap lw", obs);
    run_op(0, 1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0, 1'b0, "wrap lh", obs);

    $display("[TB] reset during a split store");
    clear_mem(0);
    @(negedge clock);
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 32'd2;
    req_wdata    = 32'hDEAD_BEEF;
    req_valid_m  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid_m = 1'b0;
    reset_n     = 1'b0;
    #1;
    check_output("midrst ready", 32'(m_req_ready), 32'd0);
    check_output("midrst w_enable", 32'(m_ram_w_enable), 32'd0);
    check_output("midrst resp_valid", 32'(m_resp_valid), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_output("postrst ready", 32'(m_req_ready), 32'd1);
    resp_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      #1;
      if (m_resp_valid || m_ram_w_enable) resp_seen++;
    end
    check_output("postrst quiet", 32'(resp_seen), 32'd0);
    model[0][2] = 8'hEF;
    compare_mem(0, "midrst mem");

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      st   = 1'($urandom);
      f3   = 3'($urandom);
      addr = ($urandom_range(7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(3)))
                                      : 32'($urandom_range(63));
      run_op(0, st, f3, addr, $urandom, 1'($urandom), $sformatf("rnd%0d", i), obs);
    end
    for (int i = 0; i < 12; i++) begin
      st   = 1'($urandom);
      f3   = 3'($urandom);
      addr = 32'($urandom_range(63));
      run_op(1, st, f3, addr, $urandom, 1'($urandom), $sformatf("rnd strict%0d", i), obs);
    end
    compare_mem(0, "final mem");
    compare_mem(1, "final strict mem");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
